// File: rtl/link_sched_if.sv
// Requester/link-side signal bundle for link_sched: two frame requesters
// plus the serial line and its status.
interface link_sched_if;
    logic        en;
    logic        up_req;
    logic [20:0] up_frame;
    logic        up_ack;
    logic        dn_req;
    logic [12:0] dn_frame;
    logic        dn_ack;
    logic        sen;
    logic        sd;
    logic        updown;
    logic        busy;
    logic [3:0]  up_cnt;
    logic [4:0]  dn_cnt;

    modport master (
        output en, up_req, up_frame, dn_req, dn_frame,
        input  up_ack, dn_ack, sen, sd, updown, busy, up_cnt, dn_cnt
    );

    modport slave (
        input  en, up_req, up_frame, dn_req, dn_frame,
        output up_ack, dn_ack, sen, sd, updown, busy, up_cnt, dn_cnt
    );
endinterface

// File: rtl/link_sched.sv
// Half-duplex serial link scheduler: arbitrates upload/download frames
// round-robin, inserts a turnaround cycle on direction change, shifts MSB first.
module link_sched (
    input  logic        clk,
    input  logic        rst,
    link_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, TURN, SHIFT} state_t;

    localparam logic [4:0] UP_LEN = 5'd21;
    localparam logic [4:0] DN_LEN = 5'd13;

    state_t      state, state_nx;
    logic        updown_q, updown_nx;
    logic        favour_dn_q, favour_dn_nx;
    logic [20:0] shreg_q, shreg_nx;
    logic [4:0]  bit_cnt_q, bit_cnt_nx;
    logic        up_ack_q, up_ack_nx;
    logic        dn_ack_q, dn_ack_nx;
    logic        sen_q, sen_nx;
    logic        sd_q, sd_nx;
    logic        busy_q, busy_nx;
    logic [3:0]  up_cnt_q, up_cnt_nx;
    logic [4:0]  dn_cnt_q, dn_cnt_nx;

    logic        grant_dn;
    logic [20:0] grant_frame;
    logic [4:0]  grant_len;

    // The shift register holds the bits still to be sent, left-aligned;
    // bit_cnt counts the bits remaining after the one currently on sd.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nx     = state;
        updown_nx    = updown_q;
        favour_dn_nx = favour_dn_q;
        shreg_nx     = shreg_q;
        bit_cnt_nx   = bit_cnt_q;
        up_ack_nx    = 1'b0;
        dn_ack_nx    = 1'b0;
        sen_nx       = 1'b1;
        sd_nx        = 1'b0;
        up_cnt_nx    = up_cnt_q;
        dn_cnt_nx    = dn_cnt_q;
        grant_dn     = bus.dn_req && (!bus.up_req || favour_dn_q);
        grant_frame  = grant_dn ? {bus.dn_frame, 8'h00} : bus.up_frame;
        grant_len    = grant_dn ? DN_LEN : UP_LEN;

        case (state)
            IDLE: begin
                if (bus.en && (bus.up_req || bus.dn_req)) begin
                    favour_dn_nx = !grant_dn;
                    up_ack_nx    = !grant_dn;
                    dn_ack_nx    = grant_dn;
                    if (grant_dn == updown_q) begin
                        state_nx   = SHIFT;
                        sen_nx     = 1'b0;
                        sd_nx      = grant_frame[20];
                        shreg_nx   = {grant_frame[19:0], 1'b0};
                        bit_cnt_nx = grant_len - 5'd1;
                    end else begin
                        // Direction change: one idle turnaround cycle first.
                        state_nx   = TURN;
                        updown_nx  = grant_dn;
                        shreg_nx   = grant_frame;
                        bit_cnt_nx = grant_len;
                    end
                end
            end

            TURN, SHIFT: begin
                if (state == SHIFT && bit_cnt_q == 5'd0) begin
                    state_nx = IDLE;
                    if (!updown_q) begin
                        if (up_cnt_q != 4'hF) up_cnt_nx = up_cnt_q + 4'd1;
                    end else begin
                        if (dn_cnt_q != 5'h1F) dn_cnt_nx = dn_cnt_q + 5'd1;
                    end
                end else begin
                    state_nx   = SHIFT;
                    sen_nx     = 1'b0;
                    sd_nx      = shreg_q[20];
                    shreg_nx   = {shreg_q[19:0], 1'b0};
                    bit_cnt_nx = bit_cnt_q - 5'd1;
                end
            end

            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            updown_q    <= 1'b0;
            favour_dn_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            up_ack_q    <= 1'b0;
            dn_ack_q    <= 1'b0;
            sen_q       <= 1'b1;
            sd_q        <= 1'b0;
            busy_q      <= 1'b0;
            up_cnt_q    <= '0;
            dn_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state       <= state_nx;
            updown_q    <= updown_nx;
            favour_dn_q <= favour_dn_nx;
            shreg_q     <= shreg_nx;
            bit_cnt_q   <= bit_cnt_nx;
            up_ack_q    <= up_ack_nx;
            dn_ack_q    <= dn_ack_nx;
            sen_q       <= sen_nx;
            sd_q        <= sd_nx;
            busy_q      <= busy_nx;
            up_cnt_q    <= up_cnt_nx;
            dn_cnt_q    <= dn_cnt_nx;
        end
    end

    assign bus.up_ack = up_ack_q;
    assign bus.dn_ack = dn_ack_q;
    assign bus.sen    = sen_q;
    assign bus.sd     = sd_q;
    assign bus.updown = updown_q;
    assign bus.busy   = busy_q;
    assign bus.up_cnt = up_cnt_q;
    assign bus.dn_cnt = dn_cnt_q;

endmodule

// File: tb/tb_link_sched.sv
// Directed bench for link_sched: a line deserializer collects frames, and
// hand-computed frames, gaps, acks and counters are compared against it.
module tb_link_sched;

    logic clk;
    logic rst;

    link_sched_if bus ();

    link_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [20:0] data;
        int          len;
        logic        dir;
        int          gap;
    } frame_t;

    frame_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line monitor: deserializes sen-low runs, measures the sen-high gap before each.
    logic [20:0] acc = '0;
    int   mon_len = 0, gap_cnt = 0, cur_gap = 0;
    logic cur_dir = 1'b0;
    int   sd_idle_err = 0, ack_len_err = 0, both_ack_err = 0;
    int   up_ack_cnt = 0, dn_ack_cnt = 0;
    logic prev_up = 1'b0, prev_dn = 1'b0;

    always @(negedge clk) begin
        if (bus.sen === 1'b0) begin
            if (mon_len == 0) begin
                cur_gap = gap_cnt;
                cur_dir = bus.updown;
            end
            acc = {acc[19:0], bus.sd};
            mon_len++;
            gap_cnt = 0;
        end else begin
            if (mon_len > 0) begin
                q.push_back('{data: acc, len: mon_len, dir: cur_dir, gap: cur_gap});
                mon_len = 0;
                acc = '0;
            end
            gap_cnt++;
            if (bus.sd === 1'b1) sd_idle_err++;
        end
        if (bus.up_ack === 1'b1) up_ack_cnt++;
        if (bus.dn_ack === 1'b1) dn_ack_cnt++;
        if (bus.up_ack === 1'b1 && bus.dn_ack === 1'b1) both_ack_err++;
        if (bus.up_ack === 1'b1 && prev_up) ack_len_err++;
        if (bus.dn_ack === 1'b1 && prev_dn) ack_len_err++;
        prev_up = (bus.up_ack === 1'b1);
        prev_dn = (bus.dn_ack === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int c = 0;
        while (q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_frames"}, q.size(), n);
    endtask

    task automatic wait_ack(input string tag, input logic dn, input int budget);
        int c = 0;
        logic seen = 1'b0;
        while (!seen && c < budget) begin
            tick();
            c++;
            seen = dn ? bus.dn_ack : bus.up_ack;
        end
        check({tag, "_ack"}, seen, 1'b1);
    endtask

    task automatic check_frame(input string tag, input logic [20:0] exp_data,
                               input int exp_len, input logic exp_dir, input int exp_gap);
        frame_t f;
        if (q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            f = q.pop_front();
            check({tag, "_data"}, f.data, exp_data);
            check({tag, "_len"}, f.len, exp_len);
            check({tag, "_dir"}, f.dir, exp_dir);
            if (exp_gap >= 0) check({tag, "_gap"}, f.gap, exp_gap);
        end
    endtask

    function automatic logic [20:0] stream_frame(input int k);
        logic [2:0]  a;
        logic [17:0] d;
        a = 3'(k);
        d = 18'h2A000 + 18'(k);
        return {a, d};
    endfunction

    initial begin
        int acks;
        int k;
        int c;
        int ack_before;
        logic [1:0] order [4];

        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.up_req   = 1'b0;
        bus.up_frame = '0;
        bus.dn_req   = 1'b0;
        bus.dn_frame = '0;

        // Reset takes effect before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_sen", bus.sen, 1'b1);
        check("rst_sd", bus.sd, 1'b0);
        check("rst_updown", bus.updown, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_up_ack", bus.up_ack, 1'b0);
        check("rst_dn_ack", bus.dn_ack, 1'b0);
        check("rst_up_cnt", bus.up_cnt, 4'd0);
        check("rst_dn_cnt", bus.dn_cnt, 5'd0);
        tick();
        tick();
        rst    = 1'b1;
        bus.en = 1'b1;

        // Single upload frame; frame input changes after capture.
        tick();
        bus.up_frame = 21'h0AB55;
        bus.up_req   = 1'b1;
        wait_ack("up1", 1'b0, 5);
        check("up1_sen", bus.sen, 1'b0);
        check("up1_busy", bus.busy, 1'b1);
        check("up1_dn_ack", bus.dn_ack, 1'b0);
        bus.up_req   = 1'b0;
        bus.up_frame = 21'h1FFFFF;
        wait_frames("up1", 1, 40);
        check_frame("up1", 21'h0AB55, 21, 1'b0, -1);
        check("up1_cnt", bus.up_cnt, 4'd1);
        check("up1_idle_busy", bus.busy, 1'b0);

        // Direction change: turnaround then 13 download bits.
        bus.dn_frame = 13'h1A5C;
        bus.dn_req   = 1'b1;
        tick();
        check("dn1_ack", bus.dn_ack, 1'b1);
        check("dn1_up_ack", bus.up_ack, 1'b0);
        check("dn1_updown", bus.updown, 1'b1);
        check("dn1_turn_sen", bus.sen, 1'b1);
        check("dn1_turn_sd", bus.sd, 1'b0);
        check("dn1_turn_busy", bus.busy, 1'b1);
        bus.dn_req   = 1'b0;
        bus.dn_frame = 13'h0000;
        tick();
        check("dn1_first_sen", bus.sen, 1'b0);
        check("dn1_first_sd", bus.sd, 1'b1);
        wait_frames("dn1", 1, 40);
        check_frame("dn1", 21'h01A5C, 13, 1'b1, 2);
        check("dn1_cnt", bus.dn_cnt, 5'd1);
        check("dn1_up_cnt", bus.up_cnt, 4'd1);

        // Contention: both held, grants alternate starting with upload.
        bus.up_frame = 21'h15A0F3;
        bus.dn_frame = 13'h0ACE;
        bus.up_req   = 1'b1;
        bus.dn_req   = 1'b1;
        acks = 0;
        c    = 0;
        while (acks < 4 && c < 200) begin
            tick();
            c++;
            if (bus.up_ack || bus.dn_ack) begin
                order[acks] = {bus.dn_ack, bus.up_ack};
                acks++;
            end
        end
        bus.up_req = 1'b0;
        bus.dn_req = 1'b0;
        check("rr_ack_count", acks, 4);
        for (int i = 0; i < acks; i++)
            check($sformatf("rr_order%0d", i), order[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        wait_frames("rr", 4, 200);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) check_frame($sformatf("rr%0d", i), 21'h15A0F3, 21, 1'b0, 2);
            else            check_frame($sformatf("rr%0d", i), 21'h00ACE, 13, 1'b1, 2);
        end
        check("rr_up_cnt", bus.up_cnt, 4'd3);
        check("rr_dn_cnt", bus.dn_cnt, 5'd3);

        // Back-to-back upload stream from a fresh reset.
        rst = 1'b0;
        #1;
        check("rst2_up_cnt", bus.up_cnt, 4'd0);
        tick();
        rst = 1'b1;
        q.delete();
        k = 0;
        c = 0;
        bus.up_frame = stream_frame(0);
        bus.up_req   = 1'b1;
        while (k < 8 && c < 400) begin
            tick();
            c++;
            if (bus.up_ack) begin
                k++;
                if (k == 8) bus.up_req = 1'b0;
                else        bus.up_frame = stream_frame(k);
            end
        end
        bus.up_req = 1'b0;
        check("str_acks", k, 8);
        wait_frames("str", 8, 100);
        for (int i = 0; i < 8; i++)
            check_frame($sformatf("str%0d", i), stream_frame(i), 21, 1'b0, (i == 0) ? -1 : 1);
        check("str_up_cnt", bus.up_cnt, 4'd8);
        check("str_dn_cnt", bus.dn_cnt, 5'd0);

        // Reset in the middle of a download abandons it.
        bus.dn_frame = 13'h0F3C;
        bus.dn_req   = 1'b1;
        wait_ack("abort", 1'b1, 5);
        c = 0;
        while (bus.sen !== 1'b0 && c < 5) begin
            tick();
            c++;
        end
        for (int i = 0; i < 9; i++) tick();
        check("abort_mid_sen", bus.sen, 1'b0);
        check("abort_pre_dn_cnt", bus.dn_cnt, 5'd0);
        rst = 1'b0;
        #1;
        check("abort_sen", bus.sen, 1'b1);
        check("abort_sd", bus.sd, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_dn_cnt", bus.dn_cnt, 5'd0);
        check("abort_updown", bus.updown, 1'b0);
        tick();
        tick();
        check("abort_rst_dn_ack", bus.dn_ack, 1'b0);
        q.delete();
        rst = 1'b1;
        tick();
        check("abort_regrant_ack", bus.dn_ack, 1'b1);
        check("abort_regrant_updown", bus.updown, 1'b1);
        bus.dn_req = 1'b0;
        wait_frames("abort", 1, 40);
        check_frame("abort_full", 21'h00F3C, 13, 1'b1, -1);
        check("abort_dn_cnt_after", bus.dn_cnt, 5'd1);

        // en dropped mid-frame: frame finishes, nothing new until en returns.
        bus.up_frame = 21'h0C3A5;
        bus.dn_frame = 13'h1111;
        bus.up_req   = 1'b1;
        bus.dn_req   = 1'b1;
        wait_ack("en", 1'b0, 5);
        bus.en = 1'b0;
        wait_frames("en", 1, 40);
        check_frame("en_up", 21'h0C3A5, 21, 1'b0, -1);
        ack_before = up_ack_cnt + dn_ack_cnt;
        for (int i = 0; i < 5; i++) tick();
        check("en_hold_acks", up_ack_cnt + dn_ack_cnt, ack_before);
        check("en_hold_busy", bus.busy, 1'b0);
        check("en_hold_sen", bus.sen, 1'b1);
        check("en_hold_updown", bus.updown, 1'b0);
        bus.en = 1'b1;
        tick();
        check("en_resume_dn_ack", bus.dn_ack, 1'b1);
        check("en_resume_up_ack", bus.up_ack, 1'b0);
        bus.up_req = 1'b0;
        bus.dn_req = 1'b0;
        wait_frames("en_dn", 1, 40);
        check_frame("en_dn", 21'h01111, 13, 1'b1, -1);
        check("en_up_cnt", bus.up_cnt, 4'd1);
        check("en_dn_cnt", bus.dn_cnt, 5'd2);

        // Line-wide properties gathered by the monitor.
        check("idle_sd_zero", sd_idle_err, 0);
        check("ack_one_cycle", ack_len_err, 0);
        check("ack_exclusive", both_ack_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
